// File: rtl/mips_alu_if.sv
// ALU issue/result bus: operands and decode fields in, registered result out.
// Optional ovf signal is present only when ALU_OVERFLOW_EN is defined.
interface mips_alu_if;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned IMM_W   = 16;

    logic [OP_W-1:0]    opcode;
    logic [DATA_W-1:0]  rs_content;
    logic [DATA_W-1:0]  rt_content;
    logic [SHAMT_W-1:0] shamt;
    logic [OP_W-1:0]    ALU_control;
    logic [IMM_W-1:0]   immediate;
    logic [DATA_W-1:0]  ALU_result;
    logic               sig_branch;
`ifdef ALU_OVERFLOW_EN
    logic               ovf;
`endif

    // Issuing side (execute-stage control / testbench)
    modport master (
        output opcode, rs_content, rt_content, shamt, ALU_control, immediate,
        input  ALU_result, sig_branch
`ifdef ALU_OVERFLOW_EN
        , input ovf
`endif
    );

    // ALU side
    modport slave (
        input  opcode, rs_content, rt_content, shamt, ALU_control, immediate,
        output ALU_result, sig_branch
`ifdef ALU_OVERFLOW_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/mips_alu.sv
// MIPS-style 32-bit integer ALU with one cycle of registered latency.
// Decodes R-type funct (opcode 0) or I-type opcode; computes result and branch flag.
// Optional macro ALU_OVERFLOW_EN adds a registered signed-overflow flag (ovf).
module mips_alu (
    input  logic      clk,
    input  logic      rst_n,
    mips_alu_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IMM_W  = 16;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] zimm;
    logic [DATA_W-1:0] sum_rt;
    logic [DATA_W-1:0] diff_rt;
    logic [DATA_W-1:0] sum_imm;
    logic [4:0]        var_amt;
    logic [DATA_W-1:0] result_c;
    logic              branch_c;
    logic              ovf_c;

    // Operand preparation shared by several decodes
    always_comb begin
        rs      = bus.rs_content;
        rt      = bus.rt_content;
        simm    = {{(DATA_W-IMM_W){bus.immediate[IMM_W-1]}}, bus.immediate};
        zimm    = {{(DATA_W-IMM_W){1'b0}}, bus.immediate};
        sum_rt  = rs + rt;
        diff_rt = rs - rt;
        sum_imm = rs + simm;
        var_amt = rs[4:0];
    end

    // Next-value decode; undefined codes fall through to all-zero outputs
    always_comb begin
        result_c = '0;
        branch_c = 1'b0;
        ovf_c    = 1'b0;
        case (bus.opcode)
            OP_RTYPE: begin
                case (bus.ALU_control)
                    FN_SLL:  result_c = rt << bus.shamt;
                    FN_SRL:  result_c = rt >> bus.shamt;
                    FN_SRA:  result_c = DATA_W'($signed(rt) >>> bus.shamt);
                    FN_SLLV: result_c = rt << var_amt;
                    FN_SRLV: result_c = rt >> var_amt;
                    FN_SRAV: result_c = DATA_W'($signed(rt) >>> var_amt);
                    FN_ADD: begin
                        result_c = sum_rt;
                        ovf_c    = (rs[31] == rt[31]) && (sum_rt[31] != rs[31]);
                    end
                    FN_ADDU: result_c = sum_rt;
                    FN_SUB: begin
                        result_c = diff_rt;
                        ovf_c    = (rs[31] != rt[31]) && (diff_rt[31] != rs[31]);
                    end
                    FN_SUBU: result_c = diff_rt;
                    FN_AND:  result_c = rs & rt;
                    FN_OR:   result_c = rs | rt;
                    FN_XOR:  result_c = rs ^ rt;
                    FN_NOR:  result_c = ~(rs | rt);
                    FN_SLT:  result_c = {31'd0, $signed(rs) < $signed(rt)};
                    FN_SLTU: result_c = {31'd0, rs < rt};
                    default: result_c = '0;
                endcase
            end
            OP_ADDI: begin
                result_c = sum_imm;
                ovf_c    = (rs[31] == simm[31]) && (sum_imm[31] != rs[31]);
            end
            OP_ADDIU: result_c = sum_imm;
            OP_SLTI:  result_c = {31'd0, $signed(rs) < $signed(simm)};
            OP_SLTIU: result_c = {31'd0, rs < simm};
            OP_ANDI:  result_c = rs & zimm;
            OP_ORI:   result_c = rs | zimm;
            OP_XORI:  result_c = rs ^ zimm;
            OP_LUI:   result_c = {bus.immediate, 16'h0000};
            OP_LW:    result_c = sum_imm;
            OP_SW:    result_c = sum_imm;
            OP_BEQ: begin
                result_c = diff_rt;
                branch_c = (rs == rt);
            end
            OP_BNE: begin
                result_c = diff_rt;
                branch_c = (rs != rt);
            end
            default: begin
                result_c = '0;
                branch_c = 1'b0;
            end
        endcase
    end

    // Output registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ALU_result <= '0;
            bus.sig_branch <= 1'b0;
        end else begin
            bus.ALU_result <= result_c;
            bus.sig_branch <= branch_c;
        end
    end

`ifdef ALU_OVERFLOW_EN
    // Signed-overflow flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ovf <= 1'b0;
        end else begin
            bus.ovf <= ovf_c;
        end
    end
`else
    // Overflow decode has no consumer in this build
    logic unused_ovf;
    assign unused_ovf = ovf_c;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Directed self-checking bench for mips_alu.
module tb_mips_alu;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mips_alu_if bus();

    mips_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] exp_res;
        logic        exp_br;
    } vec_t;

    // Present one operation, then sample 1 time unit after the capturing edge
    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] sh, input logic [15:0] imm);
        bus.opcode      = op;
        bus.ALU_control = fn;
        bus.rs_content  = rs;
        bus.rt_content  = rt;
        bus.shamt       = sh;
        bus.immediate   = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(6'b000000, 6'b100000, 32'd5, 32'd6, 5'd0, 16'd0);
        drive(6'b000000, 6'b100000, 32'd5, 32'd6, 5'd0, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'd0) begin
            errors++; $display("FAIL reset_result got %h want %h", bus.ALU_result, 32'd0);
        end
        checks++;
        if (bus.sig_branch !== 1'b0) begin
            errors++; $display("FAIL reset_branch got %b want 0", bus.sig_branch);
        end
`ifdef ALU_OVERFLOW_EN
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++; $display("FAIL reset_ovf got %b want 0", bus.ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_or();
        drive(6'b000000, 6'b100101, 32'b101, 32'b010, 5'd0, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'b111) begin
            errors++; $display("FAIL or_101_010 got %h want %h", bus.ALU_result, 32'b111);
        end
        checks++;
        if (bus.sig_branch !== 1'b0) begin
            errors++; $display("FAIL or_branch got %b want 0", bus.sig_branch);
        end
        drive(6'b000000, 6'b100101, 32'b11111, 32'b11111, 5'd0, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'b11111) begin
            errors++; $display("FAIL or_same got %h want %h", bus.ALU_result, 32'b11111);
        end
        drive(6'b000000, 6'b100101, 32'b1001, 32'b1011, 5'd0, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'b1011) begin
            errors++; $display("FAIL or_1001_1011 got %h want %h", bus.ALU_result, 32'b1011);
        end
    endtask

    task automatic test_shift_compare();
        drive(6'b000000, 6'b000011, 32'd0, 32'h8000_0000, 5'd4, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'hF800_0000) begin
            errors++; $display("FAIL sra_neg got %h want %h", bus.ALU_result, 32'hF800_0000);
        end
        drive(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'd1) begin
            errors++; $display("FAIL slt_m1_1 got %h want %h", bus.ALU_result, 32'd1);
        end
        drive(6'b000000, 6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd0, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'd0) begin
            errors++; $display("FAIL sltu_m1_1 got %h want %h", bus.ALU_result, 32'd0);
        end
    endtask

    task automatic test_branch();
        drive(6'b000100, 6'b000000, 32'd7, 32'd7, 5'd0, 16'd0);
        checks++;
        if (bus.sig_branch !== 1'b1) begin
            errors++; $display("FAIL beq_eq_branch got %b want 1", bus.sig_branch);
        end
        checks++;
        if (bus.ALU_result !== 32'd0) begin
            errors++; $display("FAIL beq_eq_result got %h want %h", bus.ALU_result, 32'd0);
        end
        drive(6'b000101, 6'b000000, 32'd7, 32'd7, 5'd0, 16'd0);
        checks++;
        if (bus.sig_branch !== 1'b0) begin
            errors++; $display("FAIL bne_eq_branch got %b want 0", bus.sig_branch);
        end
        drive(6'b000101, 6'b000000, 32'd9, 32'd7, 5'd0, 16'd0);
        checks++;
        if (bus.sig_branch !== 1'b1 || bus.ALU_result !== 32'd2) begin
            errors++; $display("FAIL bne_ne got br=%b res=%h want br=1 res=%h",
                               bus.sig_branch, bus.ALU_result, 32'd2);
        end
        drive(6'b000100, 6'b000000, 32'd9, 32'd7, 5'd0, 16'd0);
        checks++;
        if (bus.sig_branch !== 1'b0) begin
            errors++; $display("FAIL beq_ne_branch got %b want 0", bus.sig_branch);
        end
        drive(6'b100011, 6'b000000, 32'd100, 32'd0, 5'd0, 16'hFFFC);
        checks++;
        if (bus.ALU_result !== 32'd96 || bus.sig_branch !== 1'b0) begin
            errors++; $display("FAIL lw_addr got res=%h br=%b want res=%h br=0",
                               bus.ALU_result, bus.sig_branch, 32'd96);
        end
    endtask

    // Back-to-back table of mixed R/I operations, one per cycle
    task automatic test_back_to_back();
        vec_t v[20];
        v[0]  = '{"sll31",   6'h00, 6'b000000, 32'd0,        32'd1,         5'd31, 16'h0000, 32'h8000_0000, 1'b0};
        v[1]  = '{"srl31",   6'h00, 6'b000010, 32'd0,        32'h8000_0000, 5'd31, 16'h0000, 32'h0000_0001, 1'b0};
        v[2]  = '{"sll0",    6'h00, 6'b000000, 32'd0,        32'hDEAD_BEEF, 5'd0,  16'h0000, 32'hDEAD_BEEF, 1'b0};
        v[3]  = '{"srav",    6'h00, 6'b000111, 32'h24,       32'hF000_0000, 5'd0,  16'h0000, 32'hFF00_0000, 1'b0};
        v[4]  = '{"sllv",    6'h00, 6'b000100, 32'd8,        32'd1,         5'd0,  16'h0000, 32'h0000_0100, 1'b0};
        v[5]  = '{"srlv",    6'h00, 6'b000110, 32'd4,        32'hF0,        5'd0,  16'h0000, 32'h0000_000F, 1'b0};
        v[6]  = '{"nor",     6'h00, 6'b100111, 32'd0,        32'd0,         5'd0,  16'h0000, 32'hFFFF_FFFF, 1'b0};
        v[7]  = '{"sub_wrap",6'h00, 6'b100010, 32'd0,        32'd1,         5'd0,  16'h0000, 32'hFFFF_FFFF, 1'b0};
        v[8]  = '{"and",     6'h00, 6'b100100, 32'hF0F0,     32'hFF00,      5'd0,  16'h0000, 32'h0000_F000, 1'b0};
        v[9]  = '{"xor",     6'h00, 6'b100110, 32'hFF,       32'h0F,        5'd0,  16'h0000, 32'h0000_00F0, 1'b0};
        v[10] = '{"addu_wr", 6'h00, 6'b100001, 32'hFFFF_FFFF,32'd2,         5'd0,  16'h0000, 32'h0000_0001, 1'b0};
        v[11] = '{"bad_fn",  6'h00, 6'b111111, 32'd3,        32'd4,         5'd0,  16'h0000, 32'h0000_0000, 1'b0};
        v[12] = '{"lui",     6'h0F, 6'b000000, 32'd7,        32'd0,         5'd0,  16'h1234, 32'h1234_0000, 1'b0};
        v[13] = '{"andi_z",  6'h0C, 6'b000000, 32'hFFFF_FFFF,32'd0,         5'd0,  16'h8001, 32'h0000_8001, 1'b0};
        v[14] = '{"ori_z",   6'h0D, 6'b000000, 32'd0,        32'd0,         5'd0,  16'hFFFF, 32'h0000_FFFF, 1'b0};
        v[15] = '{"sltiu",   6'h0B, 6'b000000, 32'd5,        32'd0,         5'd0,  16'hFFFF, 32'h0000_0001, 1'b0};
        v[16] = '{"slti",    6'h0A, 6'b000000, 32'd5,        32'd0,         5'd0,  16'hFFFF, 32'h0000_0000, 1'b0};
        v[17] = '{"addi",    6'h08, 6'b000000, 32'd10,       32'd0,         5'd0,  16'hFFFE, 32'h0000_0008, 1'b0};
        v[18] = '{"bad_op",  6'h3F, 6'b100000, 32'd123,      32'd1,         5'd0,  16'h0001, 32'h0000_0000, 1'b0};
        v[19] = '{"sw",      6'h2B, 6'b000000, 32'h1000,     32'd0,         5'd0,  16'h0010, 32'h0000_1010, 1'b0};
        for (int i = 0; i < 20; i++) begin
            drive(v[i].op, v[i].fn, v[i].rs, v[i].rt, v[i].sh, v[i].imm);
            checks++;
            if (bus.ALU_result !== v[i].exp_res || bus.sig_branch !== v[i].exp_br) begin
                errors++;
                $display("FAIL b2b_%s got res=%h br=%b want res=%h br=%b", v[i].name,
                         bus.ALU_result, bus.sig_branch, v[i].exp_res, v[i].exp_br);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(6'b000000, 6'b100000, 32'd3, 32'd4, 5'd0, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'd7) begin
            errors++; $display("FAIL pre_reset_add got %h want %h", bus.ALU_result, 32'd7);
        end
        bus.rs_content = 32'd10;
        bus.rt_content = 32'd20;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ALU_result !== 32'd0) begin
            errors++; $display("FAIL async_clear got %h want %h", bus.ALU_result, 32'd0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.ALU_result !== 32'd0) begin
            errors++; $display("FAIL reset_hold got %h want %h", bus.ALU_result, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ALU_result !== 32'd30) begin
            errors++; $display("FAIL post_release got %h want %h", bus.ALU_result, 32'd30);
        end
    endtask

`ifdef ALU_OVERFLOW_EN
    task automatic test_overflow();
        drive(6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'd1, 5'd0, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'h8000_0000 || bus.ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_add got res=%h ovf=%b want res=80000000 ovf=1",
                               bus.ALU_result, bus.ovf);
        end
        drive(6'b000000, 6'b100001, 32'h7FFF_FFFF, 32'd1, 5'd0, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'h8000_0000 || bus.ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_addu got res=%h ovf=%b want res=80000000 ovf=0",
                               bus.ALU_result, bus.ovf);
        end
        drive(6'b000000, 6'b100010, 32'h8000_0000, 32'd1, 5'd0, 16'd0);
        checks++;
        if (bus.ALU_result !== 32'h7FFF_FFFF || bus.ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_sub got res=%h ovf=%b want res=7fffffff ovf=1",
                               bus.ALU_result, bus.ovf);
        end
        drive(6'b001000, 6'b000000, 32'h7FFF_FFFF, 32'd0, 5'd0, 16'h0001);
        checks++;
        if (bus.ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_addi got %b want 1", bus.ovf);
        end
        drive(6'b000000, 6'b100000, 32'd1, 32'd2, 5'd0, 16'd0);
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_none got %b want 0", bus.ovf);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.opcode      = '0;
        bus.ALU_control = '0;
        bus.rs_content  = '0;
        bus.rt_content  = '0;
        bus.shamt       = '0;
        bus.immediate   = '0;
        test_reset();
        test_or();
        test_shift_compare();
        test_branch();
        test_back_to_back();
        test_reset_midstream();
`ifdef ALU_OVERFLOW_EN
        test_overflow();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
